spi_output_controller: RTL and testbench



---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_output_controller_if.sv | 22 ++
 rtl/flex_counter.sv | 23 ++
 rtl/gen_neg_edge_detect.sv | 22 ++
 rtl/gen_sync.sv | 22 ++
 rtl/spi_output_controller.sv | 115 +++++++++++
 tb/tb_spi_output_controller.sv | 220 ++++++++++++++++++++++
 7 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI result transmitter
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SENDING,
    DONE
  } spi_tx_state_t;

  localparam int         FRAME_BITS = 24;
  localparam logic [3:0] TX_HEADER  = 4'hA;

  // One mode-0 shift step: LSB leaves on MISO, idle-high 1 enters at the top
  function automatic logic [FRAME_BITS-1:0] shift_fill_one(input logic [FRAME_BITS-1:0] v);
    return {1'b1, v[FRAME_BITS-1:1]};
  endfunction

endpackage

// File: rtl/spi_output_controller_if.sv
// rtl/spi_output_controller_if.sv - result handshake and SPI pins of the transmitter
interface spi_output_controller_if;
  logic        SCK;
  logic        SS;
  logic        result_valid;
  logic [3:0]  result_digit;
  logic [15:0] result_cost;
  logic        MISO;
  logic        tx_ready;
  logic        tx_done;
  logic        overrun;

  modport master (
    output SCK, SS, result_valid, result_digit, result_cost,
    input  MISO, tx_ready, tx_done, overrun
  );

  modport slave (
    input  SCK, SS, result_valid, result_digit, result_cost,
    output MISO, tx_ready, tx_done, overrun
  );
endinterface

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - up counter with synchronous clear and rollover value
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);
  // Clear beats enable; at rollover_val the next count restarts at 1
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_out <= NUM_CNT_BITS'(1);
      else                           count_out <= count_out + NUM_CNT_BITS'(1);
    end
  end
endmodule

// File: rtl/gen_neg_edge_detect.sv
// rtl/gen_neg_edge_detect.sv - registered one-cycle pulse on a falling input
module gen_neg_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic sig,
  output logic edge_out
);
  logic sig_d;

  // Compare against last cycle's value; the pulse itself is registered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sig_d    <= RST_VAL;
      edge_out <= 1'b0;
    end else begin
      sig_d    <= sig;
      edge_out <= sig_d & ~sig;
    end
  end
endmodule

// File: rtl/gen_sync.sv
// rtl/gen_sync.sv - two-flop synchronizer with selectable reset level
module gen_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out
);
  logic meta;

  // Two stages give the first flop a full cycle to resolve metastability
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta     <= RST_VAL;
      sync_out <= RST_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end
endmodule

// File: rtl/spi_output_controller.sv
// rtl/spi_output_controller.sv - SPI slave transmitter for the 3-byte result frame
module spi_output_controller
  import spi_pkg::*;
#(
  parameter int         COST_WIDTH = 16,
  parameter logic [3:0] HEADER     = TX_HEADER
) (
  input logic                    clk,
  input logic                    n_rst,
  spi_output_controller_if.slave bus
);

  logic                  sck_gated, sck_s, ss_s;
  logic                  fall, ss_fall, ss_rise;
  logic [4:0]            bit_cnt;
  logic                  last_bit, cnt_en, cnt_clear;
  spi_tx_state_t         state;
  logic [FRAME_BITS-1:0] buffer, shreg, new_frame;
  logic                  tx_ready_r, tx_done_r, overrun_r;

  // SCK is masked by SS before synchronizing so a deselected bus never shifts
  assign sck_gated = bus.SCK & ~bus.SS;

  gen_sync #(.RST_VAL(1'b0)) u_sck_sync (.clk, .n_rst, .async_in(sck_gated), .sync_out(sck_s));
  gen_sync #(.RST_VAL(1'b1)) u_ss_sync  (.clk, .n_rst, .async_in(bus.SS),    .sync_out(ss_s));

  gen_neg_edge_detect #(.RST_VAL(1'b0)) u_sck_fall (.clk, .n_rst, .sig(sck_s), .edge_out(fall));
  gen_neg_edge_detect #(.RST_VAL(1'b1)) u_ss_fall  (.clk, .n_rst, .sig(ss_s),  .edge_out(ss_fall));
  gen_neg_edge_detect #(.RST_VAL(1'b0)) u_ss_rise  (.clk, .n_rst, .sig(~ss_s), .edge_out(ss_rise));

  // Byte 0 is header+digit, then cost high byte, then cost low byte; LSB goes out first
  assign new_frame = {bus.result_cost[COST_WIDTH/2-1:0],
                      bus.result_cost[COST_WIDTH-1:COST_WIDTH/2],
                      HEADER, bus.result_digit};

  assign last_bit  = (bit_cnt == 5'(FRAME_BITS - 1));
  assign cnt_en    = (state == SENDING) && fall;
  assign cnt_clear = ((state == LOADED) && ss_fall) ||
                     ((state == SENDING) && ss_rise && !(fall && last_bit));

  flex_counter #(.NUM_CNT_BITS(5)) u_bit_cnt (
    .clk,
    .n_rst,
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (5'(FRAME_BITS)),
    .count_out    (bit_cnt)
  );

  // Transmit FSM: owns the frame buffer, shift register and status pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      buffer     <= '0;
      shreg      <= '1;
      tx_ready_r <= 1'b0;
      tx_done_r  <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      overrun_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) shreg <= shift_fill_one(shreg);
          if (bus.result_valid) begin
            buffer     <= new_frame;
            shreg      <= new_frame;
            tx_ready_r <= 1'b1;
            state      <= LOADED;
          end
        end
        LOADED: begin
          // A load in the same cycle as ss_fall still lands before the first shift
          if (bus.result_valid) begin
            buffer <= new_frame;
            shreg  <= new_frame;
          end
          if (ss_fall) state <= SENDING;
        end
        SENDING: begin
          if (bus.result_valid) overrun_r <= 1'b1;
          if (fall && last_bit) begin
            shreg      <= shift_fill_one(shreg);
            tx_done_r  <= 1'b1;
            tx_ready_r <= 1'b0;
            state      <= DONE;
          end else if (ss_rise) begin
            shreg <= buffer;
            state <= LOADED;
          end else if (fall) begin
            shreg <= shift_fill_one(shreg);
          end
        end
        DONE: begin
          // Level test on ss_s also catches a deselect that coincided with the last bit
          if (fall) shreg <= shift_fill_one(shreg);
          if (bus.result_valid) begin
            buffer     <= new_frame;
            shreg      <= new_frame;
            tx_ready_r <= 1'b1;
            state      <= LOADED;
          end else if (ss_s) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.MISO     = ss_s ? 1'b1 : shreg[0];
  assign bus.tx_ready = tx_ready_r;
  assign bus.tx_done  = tx_done_r;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_spi_output_controller.sv
// tb/tb_spi_output_controller.sv - scoreboard bench for the SPI result transmitter
module tb_spi_output_controller;

  logic        clk;
  logic        n_rst;
  logic        sck, ss, rv;
  logic [3:0]  digit;
  logic [15:0] cost;

  int checks = 0;
  int errors = 0;

  logic  exp_bits[$];
  string exp_done[$];
  string exp_ovr[$];
  int    bit_idx = 0;
  logic  mon_bit;
  string mon_tag;

  spi_output_controller_if bus();

  assign bus.SCK          = sck;
  assign bus.SS           = ss;
  assign bus.result_valid = rv;
  assign bus.result_digit = digit;
  assign bus.result_cost  = cost;

  spi_output_controller dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int nbits);
    logic [23:0] f;
    f = {b2, b1, b0};
    for (int i = 0; i < nbits; i++) exp_bits.push_back(i < 24 ? f[i] : 1'b1);
  endtask

  task automatic pulse_result(input logic [3:0] d, input logic [15:0] c);
    @(negedge clk);
    rv = 1'b1; digit = d; cost = c;
    @(negedge clk);
    rv = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge clk);
    ss = 1'b0;
    #100;
  endtask

  task automatic sck_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1; #80;
      sck = 1'b0; #80;
    end
  endtask

  task automatic ss_high();
    ss = 1'b1;
    #100;
  endtask

  task automatic spi_xfer(input int n);
    ss_low();
    sck_pulses(n);
    ss_high();
  endtask

  task automatic drain(input string tag);
    check({tag, "_bits_left"}, exp_bits.size(), 0);
    check({tag, "_done_left"}, exp_done.size(), 0);
    check({tag, "_ovr_left"},  exp_ovr.size(),  0);
  endtask

  // Master receiver: samples MISO on each SCK rise while selected
  always @(posedge sck) begin
    if (!ss) begin
      checks++;
      if (exp_bits.size() == 0) begin
        errors++;
        $display("FAIL miso_extra bit %0d: got %0b expected no bit", bit_idx, bus.MISO);
      end else begin
        mon_bit = exp_bits.pop_front();
        if (bus.MISO !== mon_bit) begin
          errors++;
          $display("FAIL miso_bit %0d: got %0b expected %0b", bit_idx, bus.MISO, mon_bit);
        end
      end
      bit_idx++;
    end
  end

  // Status pulse monitor
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.tx_done) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL tx_done_unexpected: got 1 expected 0");
        end else mon_tag = exp_done.pop_front();
      end
      if (bus.overrun) begin
        checks++;
        if (exp_ovr.size() == 0) begin
          errors++;
          $display("FAIL overrun_unexpected: got 1 expected 0");
        end else mon_tag = exp_ovr.pop_front();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; sck = 1'b0; ss = 1'b1; rv = 1'b0; digit = '0; cost = '0;
    repeat (4) @(negedge clk);
    check("rst_miso",     bus.MISO,     1);
    check("rst_tx_ready", bus.tx_ready, 0);
    check("rst_tx_done",  bus.tx_done,  0);
    check("rst_overrun",  bus.overrun,  0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame
    pulse_result(4'd7, 16'h1234);
    @(negedge clk);
    check("t1_ready_loaded", bus.tx_ready, 1);
    push_frame(8'hA7, 8'h12, 8'h34, 24);
    exp_done.push_back("t1");
    spi_xfer(24);
    check("t1_ready_after", bus.tx_ready, 0);
    check("t1_miso_idle",   bus.MISO,     1);
    drain("t1");

    // Abort after 10 bits, then full resend
    pulse_result(4'd3, 16'h00FF);
    push_frame(8'hA3, 8'h00, 8'hFF, 10);
    spi_xfer(10);
    check("t2_ready_abort", bus.tx_ready, 1);
    drain("t2a");
    push_frame(8'hA3, 8'h00, 8'hFF, 24);
    exp_done.push_back("t2");
    spi_xfer(24);
    check("t2_ready_after", bus.tx_ready, 0);
    drain("t2");

    // Overrun during SENDING
    pulse_result(4'd2, 16'hC35A);
    push_frame(8'hA2, 8'hC3, 8'h5A, 24);
    exp_done.push_back("t3");
    exp_ovr.push_back("t3");
    fork
      spi_xfer(24);
      begin
        #1000;
        pulse_result(4'd9, 16'h9999);
      end
    join
    drain("t3");

    // Second load in LOADED replaces the first
    pulse_result(4'd1, 16'h1111);
    pulse_result(4'd5, 16'hBEEF);
    push_frame(8'hA5, 8'hBE, 8'hEF, 24);
    exp_done.push_back("t4");
    spi_xfer(24);
    drain("t4");

    // Over-clocked select: trailing bits read as 1
    pulse_result(4'd0, 16'h8001);
    push_frame(8'hA0, 8'h80, 8'h01, 30);
    exp_done.push_back("t5");
    spi_xfer(30);
    drain("t5");

    // Select while IDLE
    push_frame(8'hFF, 8'hFF, 8'hFF, 8);
    spi_xfer(8);
    check("t6_ready", bus.tx_ready, 0);
    drain("t6");

    // Reset mid-frame loses the result
    pulse_result(4'd4, 16'h5678);
    push_frame(8'hA4, 8'h56, 8'h78, 12);
    ss_low();
    sck_pulses(12);
    n_rst = 1'b0;
    #30;
    check("t7_rst_miso",     bus.MISO,     1);
    check("t7_rst_tx_ready", bus.tx_ready, 0);
    check("t7_rst_tx_done",  bus.tx_done,  0);
    n_rst = 1'b1;
    #50;
    check("t7_miso_post", bus.MISO, 1);
    push_frame(8'hFF, 8'hFF, 8'hFF, 8);
    sck_pulses(8);
    ss_high();
    check("t7_ready_post", bus.tx_ready, 0);
    drain("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
